// File: rtl/gate_reduce_pkg.sv
// Shared constants for the bitwise frame-reduction unit.
//   OP_*  : 2-bit reduction op encoding presented on the op input.
//   ST_*  : FSM state encoding for gate_reduce_unit.
package gate_reduce_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/gate_reduce_unit_if.sv
// Handshake bundle between a word producer/result consumer and gate_reduce_unit.
//   master : drives op, len, in_valid, in_data, in_last, out_ready;
//            observes in_ready, out_valid, out_data, out_count, busy.
//   slave  : the reduction unit (directions mirrored).
interface gate_reduce_unit_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5
) ();

    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LEN_W-1:0] out_count;
    logic             busy;

    modport master (
        output op, len, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, busy
    );

    modport slave (
        input  op, len, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, busy
    );

endinterface

// File: rtl/gate_op_combine.sv
// Combinational bitwise combine of two words.
//   op_i : reduction op; NAND combines as AND (inversion is applied by the parent
//          only once, on the final result)
//   a_i  : running accumulator
//   b_i  : incoming word
//   y_o  : a_i OP b_i
module gate_op_combine
    import gate_reduce_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = a_i & b_i;
        case (op_i)
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = a_i & b_i;
        endcase
    end

endmodule

// File: rtl/gate_reduce_unit.sv
// Streaming bitwise reduction of a frame of 1..MAX_LEN words.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; discards any partial frame
//   bus   : slave side of gate_reduce_unit_if
//           in_*  : word stream (valid/ready), in_last ends a frame early
//           op/len: sampled on the first beat of each frame
//           out_* : one result per frame (valid/ready), out_count = words reduced
//           busy  : frame in progress or result pending
module gate_reduce_unit
    import gate_reduce_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic clk,
    input  logic reset,
    gate_reduce_unit_if.slave bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

    // len==0 is treated as a single-word frame; oversize lengths clamp to MAX_LEN
    // so cnt can never exceed MAX_LEN.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        if (l == '0)
            r = ONE_C;
        else if (l > MAX_LEN_C)
            r = MAX_LEN_C;
        else
            r = l;
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [1:0]       op_q,    op_d;

    logic [WIDTH-1:0] comb_w;
    logic [LEN_W-1:0] cnt_inc;
    logic [LEN_W-1:0] len_eff;
    logic             beat;

    assign beat    = bus.in_valid && bus.in_ready;
    assign cnt_inc = cnt_q + ONE_C;
    assign len_eff = eff_len(bus.len);

    gate_op_combine #(
        .WIDTH (WIDTH)
    ) u_combine (
        .op_i (op_q),
        .a_i  (acc_q),
        .b_i  (bus.in_data),
        .y_o  (comb_w)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d = bus.in_data;
                    cnt_d = ONE_C;
                    op_d  = bus.op;
                    len_d = len_eff;
                    if ((len_eff == ONE_C) || bus.in_last)
                        state_d = ST_DONE;
                    else
                        state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d = comb_w;
                    cnt_d = cnt_inc;
                    if ((cnt_inc == len_q) || bus.in_last)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            op_q    <= OP_AND;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            op_q    <= op_d;
        end
    end

    // Outputs decode straight from registers; nothing is accepted while a
    // result waits, so the result is held stable under back-pressure.
    assign bus.in_ready  = (state_q != ST_DONE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_data  = (op_q == OP_NAND) ? ~acc_q : acc_q;
    assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_gate_reduce_unit.sv
module tb_gate_reduce_unit;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    localparam logic [1:0] T_AND  = 2'b00;
    localparam logic [1:0] T_OR   = 2'b01;
    localparam logic [1:0] T_XOR  = 2'b10;
    localparam logic [1:0] T_NAND = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    gate_reduce_unit_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    gate_reduce_unit #(
        .WIDTH   (WIDTH),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [LEN_W-1:0] count;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] c);
        exp_t e;
        e.data  = d;
        e.count = c;
        sb.push_back(e);
    endtask

    // Called and returns at posedge+1; one accepted beat per call.
    task automatic send_beat(input logic [1:0] op, input logic [LEN_W-1:0] len,
                             input logic [WIDTH-1:0] d, input logic last);
        int k;
        k = 0;
        bus.op       = op;
        bus.len      = len;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every result handshake is checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got data 0x%0h count %0d, required no result",
                         bus.out_data, bus.out_count);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_count", 32'(bus.out_count), 32'(e.count));
            end
        end
    end

    initial begin
        int k;
        bus.op        = T_AND;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // AND, len 3: FF & F0 & 3C = 30
        push(8'h30, 5'd3);
        send_beat(T_AND, 5'd3, 8'hFF, 1'b0);
        send_beat(T_AND, 5'd3, 8'hF0, 1'b0);
        send_beat(T_AND, 5'd3, 8'h3C, 1'b0);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        idle(1);
        check("t1_out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("t1_busy_drop", 32'(bus.busy), 32'd0);

        // XOR, len 4 with downstream stalled; a pending beat must not be taken
        bus.out_ready = 1'b0;
        push(8'h0F, 5'd4);
        send_beat(T_XOR, 5'd4, 8'h01, 1'b0);
        send_beat(T_XOR, 5'd4, 8'h02, 1'b0);
        send_beat(T_XOR, 5'd4, 8'h04, 1'b0);
        send_beat(T_XOR, 5'd4, 8'h08, 1'b0);
        bus.op       = T_AND;
        bus.len      = 5'd1;
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_out_valid_held", 32'(bus.out_valid), 32'd1);
            check("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("t2_out_data_stable", 32'(bus.out_data), 32'h0F);
            idle(1);
        end
        bus.out_ready = 1'b1;
        push(8'h77, 5'd1);
        send_beat(T_AND, 5'd1, 8'h77, 1'b0);
        idle(2);

        // OR, len 8 ended by in_last on beat 2; op change after beat 1 ignored
        push(8'h11, 5'd2);
        send_beat(T_OR, 5'd8, 8'h10, 1'b0);
        send_beat(T_AND, 5'd8, 8'h01, 1'b1);
        idle(2);

        // NAND single word, len 1 then len 0
        push(8'h5A, 5'd1);
        send_beat(T_NAND, 5'd1, 8'hA5, 1'b0);
        push(8'h5A, 5'd1);
        send_beat(T_NAND, 5'd0, 8'hA5, 1'b0);
        idle(2);

        // XOR, len 20 clamps to 16; 17th beat opens a new frame
        push(8'h00, 5'd16);
        for (int i = 0; i < 16; i++)
            send_beat(T_XOR, 5'd20, 8'h01, 1'b0);
        check("t5_done_after_16", 32'(bus.out_valid), 32'd1);
        check("t5_count_16", 32'(bus.out_count), 32'd16);
        push(8'h42, 5'd1);
        send_beat(T_OR, 5'd1, 8'h42, 1'b0);
        idle(2);

        // Asynchronous reset mid-frame, then a clean frame
        send_beat(T_AND, 5'd4, 8'h0F, 1'b0);
        send_beat(T_AND, 5'd4, 8'h0F, 1'b0);
        check("t6_busy_before", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_out_valid_rst", 32'(bus.out_valid), 32'd0);
        check("t6_busy_rst", 32'(bus.busy), 32'd0);
        check("t6_in_ready_rst", 32'(bus.in_ready), 32'd1);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        push(8'h30, 5'd2);
        send_beat(T_AND, 5'd2, 8'hF0, 1'b0);
        send_beat(T_AND, 5'd2, 8'h3C, 1'b0);
        idle(2);

        k = 0;
        while (sb.size() != 0 && k < 50) begin
            idle(1);
            k++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
